mat_vec_stream: RTL

- Parametrised successor of the fixed 3x3 constant matrix-vector unit: computes y = A·x for an N×N signed matrix A and a streamed N-element signed vector x.
- A is run-time loadable rather than hard-wired; input uses a valid/ready handshake; output is a serial stream with a valid flag.
- Sits between a serial sample source and downstream filtering/transform logic.
- Accepts back-to-back vectors at one element per cycle with no bubbles.

---
 rtl/mat_vec_pkg.sv | 20 ++
 rtl/mat_vec_stream_if.sv | 30 +++
 rtl/mat_vec_lane.sv | 49 ++++
 rtl/mat_vec_stream.sv | 138 +++++++++++++
 4 files changed

// File: rtl/mat_vec_pkg.sv
// Shared types and helpers for the streaming matrix-vector unit.
// Holds the control state enum, the output-width rule and the identity generator.
package mat_vec_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        LOAD = 1'b1
    } state_t;

    // Full-precision result width: an N-term sum of DW x CW products
    function automatic int calc_ow(input int n, input int dw, input int cw);
        return dw + cw + $clog2(n);
    endfunction

    // Identity matrix entry at (row, col)
    function automatic int ident_coef(input int row, input int col);
        return (row == col) ? 1 : 0;
    endfunction

endpackage

// File: rtl/mat_vec_stream_if.sv
// Stream bundle for mat_vec_stream: element input handshake, coefficient
// load strobe/data, serial result output and the loading flag.
// master = sample/coefficient source, slave = the matrix-vector unit.
interface mat_vec_stream_if import mat_vec_pkg::*; #(
    parameter int N  = 3,
    parameter int DW = 8,
    parameter int CW = 8
);
    localparam int OW = calc_ow(N, DW, CW);

    logic signed [DW-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic                 coef_load;
    logic signed [CW-1:0] coef_data;
    logic signed [OW-1:0] out_data;
    logic                 out_valid;
    logic                 loading;

    modport master (
        output in_data, in_valid, coef_load, coef_data,
        input  in_ready, out_data, out_valid, loading
    );

    modport slave (
        input  in_data, in_valid, coef_load, coef_data,
        output in_ready, out_data, out_valid, loading
    );

endinterface

// File: rtl/mat_vec_lane.sv
// One row of A: N coefficient registers, one multiplier and the accumulator.
// Ports: acc_en/first/col/x drive accumulation, wr_* write a coefficient,
// sum is this row's running total including the current element.
module mat_vec_lane import mat_vec_pkg::*; #(
    parameter int N   = 3,
    parameter int DW  = 8,
    parameter int CW  = 8,
    parameter int OW  = 18,
    parameter int ROW = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   acc_en,
    input  logic                   first,
    input  logic [$clog2(N)-1:0]   col,
    input  logic signed [DW-1:0]   x,
    input  logic                   wr_en,
    input  logic [$clog2(N)-1:0]   wr_col,
    input  logic signed [CW-1:0]   wr_data,
    output logic signed [OW-1:0]   sum
);

    logic signed [CW-1:0]    coef [N];
    logic signed [OW-1:0]    acc;
    logic signed [DW+CW-1:0] prod;
    logic signed [OW-1:0]    prod_ext;

    assign prod     = coef[col] * x;
    assign prod_ext = {{(OW-DW-CW){prod[DW+CW-1]}}, prod};
    // Element 0 starts a new vector, so the previous total is dropped
    assign sum      = (first ? '0 : acc) + prod_ext;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < N; c++) begin
                coef[c] <= CW'(ident_coef(ROW, c));
            end
            acc <= '0;
        end else begin
            if (wr_en) begin
                coef[wr_col] <= wr_data;
            end
            if (acc_en) begin
                acc <= sum;
            end
        end
    end

endmodule

// File: rtl/mat_vec_stream.sv
// Streaming y = A*x: elements arrive one per cycle, results leave serially.
// Ports: clock, reset (async, active-high), bus (slave side of the stream).
module mat_vec_stream import mat_vec_pkg::*; #(
    parameter int N  = 3,
    parameter int DW = 8,
    parameter int CW = 8
) (
    input  logic           clock,
    input  logic           reset,
    mat_vec_stream_if.slave bus
);

    localparam int OW = calc_ow(N, DW, CW);
    localparam int JW = $clog2(N);
    localparam logic [JW-1:0] LAST = JW'(N - 1);

    state_t               state;
    state_t               state_nxt;
    logic [JW-1:0]        elem_cnt;
    logic [JW-1:0]        out_cnt;
    logic [JW-1:0]        coef_row;
    logic [JW-1:0]        coef_col;
    logic                 accept;
    logic                 first;
    logic                 last_elem;
    logic                 coef_wr;
    logic                 coef_done;
    logic                 out_valid_q;
    logic signed [OW-1:0] sum  [N];
    logic signed [OW-1:0] obuf [N];

    assign bus.in_ready = (state == RUN);
    assign bus.loading  = (state == LOAD);
    assign accept       = bus.in_valid & bus.in_ready;
    assign first        = (elem_cnt == '0);
    assign last_elem    = accept & (elem_cnt == LAST);
    assign coef_wr      = (state == LOAD) & bus.coef_load;
    assign coef_done    = coef_wr & (coef_row == LAST) & (coef_col == LAST);

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_valid_q ? obuf[out_cnt] : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Load only between vectors; an element offered alongside the
    // request is taken first and the load waits for that vector.
    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN: begin
                if (bus.coef_load && first && !bus.in_valid) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (coef_done) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            elem_cnt <= '0;
        end else if (accept) begin
            elem_cnt <= (elem_cnt == LAST) ? '0 : elem_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            coef_row <= '0;
            coef_col <= '0;
        end else if (coef_wr) begin
            if (coef_col == LAST) begin
                coef_col <= '0;
                coef_row <= (coef_row == LAST) ? '0 : coef_row + 1'b1;
            end else begin
                coef_col <= coef_col + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        mat_vec_lane #(
            .N  (N),
            .DW (DW),
            .CW (CW),
            .OW (OW),
            .ROW(i)
        ) u_lane (
            .clock  (clock),
            .reset  (reset),
            .acc_en (accept),
            .first  (first),
            .col    (elem_cnt),
            .x      (bus.in_data),
            .wr_en  (coef_wr && (coef_row == JW'(i))),
            .wr_col (coef_col),
            .wr_data(bus.coef_data),
            .sum    (sum[i])
        );
    end

    // A new capture can only land as the previous y[N-1] is shown,
    // so it simply restarts the drain without a gap.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_cnt     <= '0;
            for (int i = 0; i < N; i++) begin
                obuf[i] <= '0;
            end
        end else if (last_elem) begin
            out_valid_q <= 1'b1;
            out_cnt     <= '0;
            for (int i = 0; i < N; i++) begin
                obuf[i] <= sum[i];
            end
        end else if (out_valid_q) begin
            if (out_cnt == LAST) begin
                out_valid_q <= 1'b0;
                out_cnt     <= '0;
            end else begin
                out_cnt <= out_cnt + 1'b1;
            end
        end
    end

endmodule
